// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings
// and the default operand width.
package serial_sub_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor: difference and borrow-out from a - b - bin.
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock: {oData_B, oData} = a - b - iB.
// Define SERIAL_SUB_OVF_EN to add the registered two's-complement overflow flag oOvf.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic             iB,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oData,
  output logic             oData_B
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             oOvf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_brw;
  logic [WIDTH-1:0] r_acc;

  logic             w_a;
  logic             w_b;
  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_next;

  assign w_a = r_a[r_cnt];
  assign w_b = r_b[r_cnt];

  full_subtractor_bit u_bit (
    .a    (w_a),
    .b    (w_b),
    .bin  (r_brw),
    .d    (w_d),
    .bout (w_bout)
  );

  // Partial result with the current difference bit dropped into place, so the
  // final edge can publish the complete word without an extra cycle.
  always_comb begin
    w_next        = r_acc;
    w_next[r_cnt] = w_d;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_brw   <= 1'b0;
      r_acc   <= '0;
      oBusy   <= 1'b0;
      oDone   <= 1'b0;
      oData   <= '0;
      oData_B <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      oOvf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          oDone <= 1'b0;
          if (iStart) begin
            r_a     <= iData_a;
            r_b     <= iData_b;
            r_brw   <= iB;
            r_cnt   <= '0;
            oBusy   <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_brw <= w_bout;
          r_acc <= w_next;
          r_cnt <= r_cnt + 1'b1;
          // On the MSB, w_a/w_b are the operand sign bits needed for overflow.
          if (r_cnt == LAST) begin
            oData   <= w_next;
            oData_B <= w_bout;
`ifdef SERIAL_SUB_OVF_EN
            oOvf    <= (w_a != w_b) && (w_d != w_a);
`endif
            oDone   <= 1'b1;
            oBusy   <= 1'b0;
            r_state <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
